ay_dac_stream: RTL

- Parametrised successor to the single-AY DAC/PWM output path. Takes CHANNELS parallel WIDTH-bit audio samples and drives two outputs.
- Output 1: a daisy-chained external serial shift-register DAC (clock, data, active-low latch).
- Output 2: one glitch-free PWM output per channel.
- Adds a one-deep pending buffer, overrun flag and configurable bit order.
- Sits between one or more PSG cores and the pad ring in the multi-project wrapper.

---
 rtl/ay_dac_stream.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/ay_dac_stream.sv
// Parallel multi-channel samples to a daisy-chained serial shift-register DAC,
// with one glitch-free PWM output per channel and a one-deep pending buffer.
module ay_dac_stream #(
   parameter int CHANNELS  = 4,
   parameter int WIDTH     = 8,
   parameter int CLKDIV    = 2,
   parameter int MSB_FIRST = 1
) (
   input  logic                        wb_clk_i,
   input  logic                        wb_rst_i,
   input  logic [CHANNELS*WIDTH-1:0]   sample_in,
   input  logic                        sample_valid,
   output logic                        busy,
   output logic                        frame_done,
   output logic                        overrun,
   output logic                        dac_clk,
   output logic                        dac_dat,
   output logic                        dac_le_n,
   output logic [CHANNELS-1:0]         pwm
);

   localparam int N  = CHANNELS * WIDTH;
   localparam int DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
   localparam int BW = $clog2(N + 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(CLKDIV - 1);
   localparam logic [BW-1:0] BITS_N   = BW'(N);
   localparam logic [BW-1:0] BITS_ONE = BW'(1);

   typedef enum logic [1:0] {IDLE, SETUP, HIGH, LATCH} state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic [DW-1:0]       r_div;
   logic [BW-1:0]       r_bits;
   logic [N-1:0]        r_sr;
   logic [N-1:0]        r_pend;
   logic                r_pend_full;
   logic [N-1:0]        r_shadow;
   logic                r_done;
   logic                r_overrun;
   logic [WIDTH-1:0]    r_cnt;

   logic                w_div_last;
   logic                w_last_bit;
   logic                w_load;
   logic                w_from_pend;
   logic                w_store_pend;
   logic                w_shift;
   logic [N-1:0]        w_src;
   logic [N-1:0]        w_seq;

   assign w_src = w_from_pend ? r_pend : sample_in;

   // Reorder so that bit N-1 is always the next bit to leave; channels are
   // already in the right order (highest channel occupies the top bits).
   for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      for (genvar gb = 0; gb < WIDTH; gb++) begin : g_bit
         if (MSB_FIRST != 0) begin : g_msb
            assign w_seq[gi*WIDTH + gb] = w_src[gi*WIDTH + gb];
         end else begin : g_lsb
            assign w_seq[gi*WIDTH + gb] = w_src[gi*WIDTH + WIDTH - 1 - gb];
         end
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_load       = 1'b0;
      w_from_pend  = 1'b0;
      w_store_pend = 1'b0;
      w_shift      = 1'b0;
      w_div_last   = (r_div == DIV_LAST);
      w_last_bit   = (r_bits == BITS_ONE);
      busy         = (r_state != IDLE);
      dac_clk      = (r_state == HIGH);
      dac_le_n     = (r_state != LATCH);
      case (r_state)
         IDLE: begin
            if (sample_valid) begin
               w_load       = 1'b1;
               w_state_next = SETUP;
            end
         end
         SETUP: begin
            w_store_pend = sample_valid;
            if (w_div_last) w_state_next = HIGH;
         end
         HIGH: begin
            w_store_pend = sample_valid;
            if (w_div_last) begin
               w_shift      = 1'b1;
               w_state_next = w_last_bit ? LATCH : SETUP;
            end
         end
         LATCH: begin
            w_store_pend = sample_valid;
            if (w_div_last) begin
               if (r_pend_full) begin
                  w_load       = 1'b1;
                  w_from_pend  = 1'b1;
                  w_state_next = SETUP;
               end else if (sample_valid) begin
                  // Empty pending on the exit cycle: start the new frame directly.
                  w_store_pend = 1'b0;
                  w_load       = 1'b1;
                  w_state_next = SETUP;
               end else begin
                  w_state_next = IDLE;
               end
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_div       <= '0;
         r_bits      <= '0;
         r_sr        <= '0;
         r_pend      <= '0;
         r_pend_full <= 1'b0;
         r_shadow    <= '0;
         r_done      <= 1'b0;
         r_overrun   <= 1'b0;
         r_cnt       <= '0;
      end else begin
         r_cnt  <= r_cnt + 1'b1;
         r_done <= (r_state == LATCH) && w_div_last;

         if (r_state == IDLE || w_div_last) begin
            r_div <= '0;
         end else begin
            r_div <= r_div + 1'b1;
         end

         // The last bit is not shifted out so dac_dat only moves on HIGH->SETUP.
         if (w_load) begin
            r_sr     <= w_seq;
            r_bits   <= BITS_N;
            r_shadow <= w_src;
         end else if (w_shift) begin
            r_bits <= r_bits - 1'b1;
            if (!w_last_bit) r_sr <= {r_sr[N-2:0], 1'b0};
         end

         if (w_store_pend) begin
            r_pend      <= sample_in;
            r_pend_full <= 1'b1;
            if (r_pend_full && !w_from_pend) r_overrun <= 1'b1;
         end else if (w_from_pend) begin
            r_pend_full <= 1'b0;
         end
      end
   end

   assign dac_dat    = r_sr[N-1];
   assign frame_done = r_done;
   assign overrun    = r_overrun;

   // Duty only follows the shadow at the counter wrap, so a period never glitches.
   for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_pwm
      logic [WIDTH-1:0] r_duty;
      logic             r_pwm;

      always_ff @(posedge wb_clk_i) begin
         if (wb_rst_i) begin
            r_duty <= '0;
            r_pwm  <= 1'b0;
         end else begin
            if (r_cnt == '1) r_duty <= r_shadow[gi*WIDTH +: WIDTH];
            r_pwm <= (r_cnt < r_duty);
         end
      end

      assign pwm[gi] = r_pwm;
   end

endmodule
